mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequencer and arbiter for the shared byte-wide RAM port.
- Accepts whole-transfer requests from instruction fetch (fixed 4-byte reads) and from the load/store unit (1/2/4-byte reads or writes), grants one at a time, and drives the RAM byte-serially.
- Returns assembled little-endian data with a one-cycle done pulse.
- Sits between the IF/LSU stages and the top-level RAM pins; transfers are non-preemptive.

Parameters:
STARVE_LIMIT, 4, consecutive LSU grants made while if_req is pending before IF is forced to win (starvation guard only).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
rdy  input  1  global ready; low freezes all state and outputs
flush  input  1  misprediction flush; aborts speculative reads
ram_din  input  8  RAM read data; registered RAM, valid one edge after ram_a is sampled
ram_dout  output  8  RAM write data
ram_a  output  32  RAM byte address
ram_wr  output  1  RAM write strobe (1 = write, 0 = read)
if_req  input  1  fetch request; held high with if_addr stable until if_done
if_addr  input  32  fetch address
if_done  output  1  one-cycle pulse; if_data valid in the same cycle
if_data  output  32  fetched instruction word
ls_req  input  1  load/store request; held high with fields stable until ls_done
ls_wr  input  1  1 = store, 0 = load
ls_len  input  3  byte count: 1, 2 or 4
ls_addr  input  32  load/store byte address
ls_wdata  input  32  store data; byte k = ls_wdata[8k+7:8k]
ls_done  output  1  one-cycle pulse; ls_rdata valid in the same cycle for loads
ls_rdata  output  32  load data, zero-extended (caller sign-extends)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, byte counter=0, starve count=0. Outputs: ram_a=0, ram_dout=0, ram_wr=0, if_done=0, ls_done=0, if_data=0, ls_rdata=0.
- Reset mid-transfer: returns to these values immediately, with no done pulse.
- Outputs: all registered.
- rdy=0: no state, counter or output changes. External RAM is stalled by the same rdy.
- States: IDLE, READ, WRITE, DONE.
- IDLE, request pending and flush=0 (accept edge E0):
  - Latch owner, address A, length N (IF: N=4), write data.
  - Drive ram_a=A.
  - Go to READ (ram_wr=0), or to WRITE (ram_wr=1, ram_dout=byte0).
- READ:
  - ram_a advances A+1 .. A+N-1 on edges E1 .. E(N-1).
  - Byte k is captured at edge E(k+2).
  - At E(N+1): result (bytes little-endian, upper bytes 0) is written to if_data or ls_rdata, the owner's done is set to 1, and state goes to DONE.
  - Latency: N+1 edges from accept (word fetch: 5).
- WRITE:
  - At edge Ek (k=1..N-1): ram_a=A+k, ram_dout=byte k, ram_wr=1.
  - At E(N): ram_wr=0, owner's done=1, go to DONE.
  - Latency: N edges; ram_wr is high for exactly N cycles.
- DONE:
  - Done pulse visible for this one cycle.
  - Requests are ignored, so the requester may still hold req this cycle.
  - Next edge: done=0, go to IDLE.
- Arbitration in IDLE:
  - Only one request pending: grant it.
  - Both pending: LSU wins, unless the starvation guard is active (see Optional Feature).
- flush:
  - Sampled in IDLE: blocks acceptance that cycle.
  - In READ: abort; next edge goes to IDLE with ram_wr=0 and no done pulse.
  - In WRITE: ignored; the store completes and ls_done pulses.
  - In DONE: the pulse already visible stays visible; requesters ignore done while flush is high.
- ls_len outside {1,2,4}: unsupported; the bench must not drive it.
- Address arithmetic: 32-bit, wraps modulo 2^32.

Optional Feature:
MEM_ARB_STARVE_GUARD_EN.
- Defined:
  - A starve counter increments, saturating at STARVE_LIMIT, on each LSU grant made while if_req=1.
  - The counter clears on any IF grant.
  - When counter >= STARVE_LIMIT and both requests are pending, IF wins.
- Undefined: strict LSU priority with no counter; IF can starve indefinitely.

Test Plan:
1. IF fetch A=0x100, RAM bytes 11,22,33,44 -> ram_a 0x100..0x103, ram_wr=0, if_data=0x44332211, if_done high exactly one cycle, 5 edges after accept.
2. Store ls_len=2, ls_addr=0x2000, ls_wdata=0x0000BEEF -> ram_wr high 2 cycles, ram_a 0x2000/0x2001, ram_dout 0xEF/0xBE, ls_done after 2 edges; RAM bytes 0x2002-0x2003 unchanged.
3. if_req and ls_req (load byte at 0x30, RAM=0x9C) raised the same cycle -> ls_rdata=0x0000009C first; IF accepted on the edge after DONE; neither request is accepted twice.
4. flush during IF read after 2 bytes captured -> no if_done, ram_a stops advancing, IDLE next edge. flush during a 4-byte store -> all 4 writes occur and ls_done pulses.
5. ls_req held continuously with if_req pending, STARVE_LIMIT=4:
   - Guard defined: IF granted after the 4th LSU grant.
   - Guard undefined: IF never granted while ls_req stays high.
6. Disturbances:
   - rdy low for 3 cycles mid word read: identical if_data, latency +3 edges.
   - rst asserted mid-write: ram_wr=0 and state IDLE without waiting for a clock edge.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates IF fetches and LSU transfers onto the shared
// byte-wide RAM port and sequences each transfer byte-serially.
// Optional feature macro: MEM_ARB_STARVE_GUARD_EN (a pending fetch wins
// after STARVE_LIMIT consecutive LSU grants made while it waited).
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic [7:0]  ram_din,
  output logic [7:0]  ram_dout,
  output logic [31:0] ram_a,
  output logic        ram_wr,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [2:0]  ls_len,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 8;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] len, len_nxt;
  logic          own_ls, own_ls_nxt;
  logic [DW-1:0] wbuf, wbuf_nxt;
  logic [DW-1:0] rbuf, rbuf_nxt;
  logic [AW-1:0] ram_a_nxt;
  logic [BW-1:0] ram_dout_nxt;
  logic          ram_wr_nxt;
  logic          if_done_nxt, ls_done_nxt;
  logic [DW-1:0] if_data_nxt, ls_rdata_nxt;
  logic          if_wins_c;
  logic          grant_ls_c;
  logic [CW-1:0] step_c;
  logic [1:0]    idx_c;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve, starve_nxt;
  assign if_wins_c = (32'(starve) >= STARVE_LIMIT);
`else
  // strict LSU priority; the limit only matters when the guard is built in
  assign if_wins_c = (STARVE_LIMIT == 0) && 1'b0;
`endif

  assign grant_ls_c = ls_req && !(if_req && if_wins_c);
  assign step_c     = CW'(cnt + CW'(1));
  assign idx_c      = 2'(cnt - CW'(1));

  // next-state and next-output logic
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    len_nxt      = len;
    own_ls_nxt   = own_ls;
    wbuf_nxt     = wbuf;
    rbuf_nxt     = rbuf;
    ram_a_nxt    = ram_a;
    ram_dout_nxt = ram_dout;
    ram_wr_nxt   = ram_wr;
    if_done_nxt  = if_done;
    ls_done_nxt  = ls_done;
    if_data_nxt  = if_data;
    ls_rdata_nxt = ls_rdata;
`ifdef MEM_ARB_STARVE_GUARD_EN
    starve_nxt   = starve;
`endif
    case (state)
      IDLE: begin
        if (!flush && (if_req || ls_req)) begin
          cnt_nxt  = '0;
          rbuf_nxt = '0;
          if (grant_ls_c) begin
            own_ls_nxt = 1'b1;
            len_nxt    = ls_len;
            ram_a_nxt  = ls_addr;
            ram_wr_nxt = ls_wr;
            if (ls_wr) begin
              ram_dout_nxt = ls_wdata[7:0];
              wbuf_nxt     = {8'h00, ls_wdata[31:8]};
              state_nxt    = WRITE;
            end else begin
              state_nxt    = READ;
            end
`ifdef MEM_ARB_STARVE_GUARD_EN
            if (if_req && (32'(starve) < STARVE_LIMIT))
              starve_nxt = SW'(starve + SW'(1));
`endif
          end else begin
            own_ls_nxt = 1'b0;
            len_nxt    = CW'(4);
            ram_a_nxt  = if_addr;
            ram_wr_nxt = 1'b0;
            state_nxt  = READ;
`ifdef MEM_ARB_STARVE_GUARD_EN
            starve_nxt = '0;
`endif
          end
        end
      end
      READ: begin
        if (flush) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = step_c;
          if (step_c < len)
            ram_a_nxt = ram_a + AW'(1);
          // RAM returns byte k two edges after its address was driven
          if (cnt != '0)
            rbuf_nxt[{idx_c, 3'b000} +: 8] = ram_din;
          if (cnt == len) begin
            state_nxt = DONE;
            if (own_ls) begin
              ls_rdata_nxt = rbuf_nxt;
              ls_done_nxt  = 1'b1;
            end else begin
              if_data_nxt  = rbuf_nxt;
              if_done_nxt  = 1'b1;
            end
          end
        end
      end
      WRITE: begin
        if (step_c < len) begin
          cnt_nxt      = step_c;
          ram_a_nxt    = ram_a + AW'(1);
          ram_dout_nxt = wbuf[7:0];
          wbuf_nxt     = {8'h00, wbuf[31:8]};
        end else begin
          ram_wr_nxt  = 1'b0;
          ls_done_nxt = 1'b1;
          state_nxt   = DONE;
        end
      end
      DONE: begin
        if_done_nxt = 1'b0;
        ls_done_nxt = 1'b0;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      state <= IDLE;
    else if (rdy) state <= state_nxt;
  end

  // datapath and output registers, frozen while rdy is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      len      <= '0;
      own_ls   <= 1'b0;
      wbuf     <= '0;
      rbuf     <= '0;
      ram_a    <= '0;
      ram_dout <= '0;
      ram_wr   <= 1'b0;
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
      if_data  <= '0;
      ls_rdata <= '0;
`ifdef MEM_ARB_STARVE_GUARD_EN
      starve   <= '0;
`endif
    end else if (rdy) begin
      cnt      <= cnt_nxt;
      len      <= len_nxt;
      own_ls   <= own_ls_nxt;
      wbuf     <= wbuf_nxt;
      rbuf     <= rbuf_nxt;
      ram_a    <= ram_a_nxt;
      ram_dout <= ram_dout_nxt;
      ram_wr   <= ram_wr_nxt;
      if_done  <= if_done_nxt;
      ls_done  <= ls_done_nxt;
      if_data  <= if_data_nxt;
      ls_rdata <= ls_rdata_nxt;
`ifdef MEM_ARB_STARVE_GUARD_EN
      starve   <= starve_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a
// registered byte RAM model stalled by rdy.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        flush = 1'b0;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req = 1'b0;
  logic        ls_wr = 1'b0;
  logic [2:0]  ls_len = 3'd1;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic        ls_done;
  logic [31:0] ls_rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:65535];
  logic        pl_en = 1'b0;
  logic [15:0] pl_a = '0;
  logic [7:0]  pl_d = '0;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_len(ls_len), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
  );

  always #5 clk = ~clk;

  // registered RAM: one-edge read latency, stalled by the same rdy
  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    else if (rdy) begin
      if (ram_wr) mem[ram_a[15:0]] <= ram_dout;
      ram_din <= mem[ram_a[15:0]];
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pl_a = a; pl_d = d; pl_en = 1'b1;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic wait_done(input bit on_ls, input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(on_ls ? ls_done : if_done) && n < limit);
  endtask

  initial begin
    int n;
    int nls;
    int nif;

    preload(16'h0100, 8'h11); preload(16'h0101, 8'h22);
    preload(16'h0102, 8'h33); preload(16'h0103, 8'h44);
    preload(16'h2002, 8'h55); preload(16'h2003, 8'h66);
    preload(16'h0030, 8'h9C);

    // reset values
    check("rst_ram_a", ram_a, 32'h0);
    check("rst_ram_dout", 32'(ram_dout), 32'h0);
    check("rst_ram_wr", 32'(ram_wr), 32'h0);
    check("rst_if_done", 32'(if_done), 32'h0);
    check("rst_ls_done", 32'(ls_done), 32'h0);
    check("rst_if_data", if_data, 32'h0);
    check("rst_ls_rdata", ls_rdata, 32'h0);
    rst = 1'b0;
    tick();

    // 1: word fetch from 0x100
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    check("f_a0", ram_a, 32'h100);
    check("f_wr", 32'(ram_wr), 32'h0);
    tick(); check("f_a1", ram_a, 32'h101);
    tick(); check("f_a2", ram_a, 32'h102);
    tick(); check("f_a3", ram_a, 32'h103);
    tick(); check("f_done_e4", 32'(if_done), 32'h0);
    tick();
    check("f_done_e5", 32'(if_done), 32'h1);
    check("f_data", if_data, 32'h44332211);
    if_req = 1'b0;
    tick();
    check("f_done_pulse", 32'(if_done), 32'h0);

    // 2: 2-byte store at 0x2000
    ls_req = 1'b1; ls_wr = 1'b1; ls_len = 3'd2; ls_addr = 32'h2000; ls_wdata = 32'h0000BEEF;
    tick();
    check("s_a0", ram_a, 32'h2000);
    check("s_d0", 32'(ram_dout), 32'hEF);
    check("s_wr0", 32'(ram_wr), 32'h1);
    tick();
    check("s_a1", ram_a, 32'h2001);
    check("s_d1", 32'(ram_dout), 32'hBE);
    check("s_wr1", 32'(ram_wr), 32'h1);
    tick();
    check("s_wr_off", 32'(ram_wr), 32'h0);
    check("s_done", 32'(ls_done), 32'h1);
    ls_req = 1'b0;
    tick();
    check("s_done_pulse", 32'(ls_done), 32'h0);
    check("s_mem0", 32'(mem[16'h2000]), 32'hEF);
    check("s_mem1", 32'(mem[16'h2001]), 32'hBE);
    check("s_mem2", 32'(mem[16'h2002]), 32'h55);
    check("s_mem3", 32'(mem[16'h2003]), 32'h66);

    // 3: simultaneous requests, LSU load wins
    if_req = 1'b1; if_addr = 32'h100;
    ls_req = 1'b1; ls_wr = 1'b0; ls_len = 3'd1; ls_addr = 32'h30;
    tick();
    check("a_ls_first", ram_a, 32'h30);
    tick();
    tick();
    check("a_ls_done", 32'(ls_done), 32'h1);
    check("a_ls_rdata", ls_rdata, 32'h0000009C);
    check("a_if_wait", 32'(if_done), 32'h0);
    ls_req = 1'b0;
    tick();
    check("a_done_ignores", ram_a, 32'h30);
    tick();
    check("a_if_accept", ram_a, 32'h100);
    wait_done(1'b0, 10, n);
    check("a_if_lat", 32'(n), 32'd5);
    check("a_if_data", if_data, 32'h44332211);
    check("a_no_ls_again", 32'(ls_done), 32'h0);
    if_req = 1'b0;
    tick(); tick(); tick();
    check("a_no_reaccept", ram_a, 32'h103);
    check("a_if_quiet", 32'(if_done), 32'h0);

    // 4a: flush during fetch after two bytes captured
    if_req = 1'b1; if_addr = 32'h100;
    tick(); tick(); tick(); tick();
    flush = 1'b1; if_req = 1'b0;
    tick();
    check("fl_no_done", 32'(if_done), 32'h0);
    check("fl_a_hold", ram_a, 32'h103);
    check("fl_wr", 32'(ram_wr), 32'h0);
    flush = 1'b0;
    tick(); check("fl_no_done2", 32'(if_done), 32'h0);
    tick(); check("fl_no_done3", 32'(if_done), 32'h0);

    // 4b: flush during a 4-byte store is ignored
    ls_req = 1'b1; ls_wr = 1'b1; ls_len = 3'd4; ls_addr = 32'h3000; ls_wdata = 32'hDDCCBBAA;
    tick();
    flush = 1'b1;
    tick(); check("fs_wr1", 32'(ram_wr), 32'h1);
    tick(); check("fs_wr2", 32'(ram_wr), 32'h1);
    flush = 1'b0;
    tick();
    check("fs_wr3", 32'(ram_wr), 32'h1);
    check("fs_a3", ram_a, 32'h3003);
    tick();
    check("fs_done", 32'(ls_done), 32'h1);
    check("fs_wr_off", 32'(ram_wr), 32'h0);
    ls_req = 1'b0;
    tick();
    check("fs_mem", {mem[16'h3003], mem[16'h3002], mem[16'h3001], mem[16'h3000]}, 32'hDDCCBBAA);

    // 5: LSU held continuously with a fetch pending
    if_req = 1'b1; if_addr = 32'h100;
    ls_req = 1'b1; ls_wr = 1'b0; ls_len = 3'd1; ls_addr = 32'h30;
    nls = 0; nif = 0;
`ifdef MEM_ARB_STARVE_GUARD_EN
    n = 0;
    do begin
      tick();
      n++;
      if (ls_done) nls++;
    end while (!if_done && n < 60);
    check("sg_if_done", 32'(if_done), 32'h1);
    check("sg_ls_grants", 32'(nls), 32'd4);
    check("sg_edges", 32'(n), 32'd22);
`else
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ls_done) nls++;
      if (if_done) nif++;
    end
    check("sp_if_starved", 32'(nif), 32'd0);
    check("sp_ls_grants", 32'(nls), 32'd10);
`endif
    if_req = 1'b0; ls_req = 1'b0;
    tick(); tick();

    // 6a: rdy low for three cycles mid fetch
    if_req = 1'b1; if_addr = 32'h100;
    tick(); check("rd_a0", ram_a, 32'h100);
    tick(); check("rd_a1", ram_a, 32'h101);
    rdy = 1'b0;
    tick(); tick(); tick();
    check("rd_frozen_a", ram_a, 32'h101);
    check("rd_frozen_done", 32'(if_done), 32'h0);
    rdy = 1'b1;
    wait_done(1'b0, 20, n);
    check("rd_latency", 32'(1 + 3 + n), 32'd8);
    check("rd_data", if_data, 32'h44332211);
    if_req = 1'b0;
    tick();

    // 6b: asynchronous reset in the middle of a store
    ls_req = 1'b1; ls_wr = 1'b1; ls_len = 3'd4; ls_addr = 32'h4000; ls_wdata = 32'h11223344;
    tick(); check("rw_wr0", 32'(ram_wr), 32'h1);
    tick();
    rst = 1'b1;
    #1;
    check("rw_async_wr", 32'(ram_wr), 32'h0);
    check("rw_async_a", ram_a, 32'h0);
    check("rw_async_dout", 32'(ram_dout), 32'h0);
    ls_req = 1'b0;
    #2 rst = 1'b0;
    nls = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ls_done) nls++;
    end
    check("rw_no_done", 32'(nls), 32'd0);
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    check("rw_idle_accept", ram_a, 32'h100);
    wait_done(1'b0, 10, n);
    check("rw_fetch_data", if_data, 32'h44332211);
    if_req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
